// File: rtl/strtstop_conditioner_pkg.sv
// Shared stopwatch definitions: conditioner FSM states and default timing constants.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    HOLD,
    RELEASE_WAIT
  } state_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_LONG_CYCLES     = 256;
  localparam int DEF_CNT_W           = 9;

endpackage

// File: rtl/strtstop_conditioner_if.sv
// Button-side bundle: raw active-low button in, conditioned levels and pulses out.
interface strtstop_conditioner_if;

  logic BTN_RAW;
  logic STRTSTOP;
  logic PRESS_PULSE;
  logic RUN;
  logic LONG_PRESS;

  modport master (
    output BTN_RAW,
    input  STRTSTOP, PRESS_PULSE, RUN, LONG_PRESS
  );

  modport slave (
    input  BTN_RAW,
    output STRTSTOP, PRESS_PULSE, RUN, LONG_PRESS
  );

endinterface

// File: rtl/strtstop_conditioner_sync_chain.sv
// Multi-flop synchroniser for an asynchronous single-bit input; resets to 1 (idle-high inputs).
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/strtstop_conditioner.sv
// Start/stop button conditioner: synchronise, debounce, and derive press pulse, run toggle and long-press clear.
module strtstop_conditioner
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  strtstop_conditioner_if.slave  btn_if
);

  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic             btn_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             strt_q, strt_d;
  logic             pulse_q, pulse_d;
  logic             run_q, run_d;
  logic             long_q, long_d;
  logic             from_hold_q, from_hold_d;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .d_i    (btn_if.BTN_RAW),
    .q_o    (btn_s)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      strt_q      <= 1'b1;
      pulse_q     <= 1'b0;
      run_q       <= 1'b0;
      long_q      <= 1'b0;
      from_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      strt_q      <= strt_d;
      pulse_q     <= pulse_d;
      run_q       <= run_d;
      long_q      <= long_d;
      from_hold_q <= from_hold_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    strt_d      = strt_q;
    pulse_d     = 1'b0;
    run_d       = run_q;
    long_d      = 1'b0;
    from_hold_d = from_hold_q;
    cnt_inc     = sat_inc(cnt_q);
    case (state_q)
      IDLE: begin
        if (!btn_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_inc == DEB_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
          strt_d  = 1'b0;
          pulse_d = 1'b1;
          run_d   = ~run_q;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      PRESSED: begin
        if (btn_s) begin
          state_d     = RELEASE_WAIT;
          cnt_d       = CNT_W'(1);
          from_hold_d = 1'b0;
        end else if (cnt_inc == LONG_MAX) begin
          // Long hold is a clear request: it wins over the toggle made at acceptance.
          state_d = HOLD;
          cnt_d   = cnt_inc;
          long_d  = 1'b1;
          run_d   = 1'b0;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      HOLD: begin
        if (btn_s) begin
          state_d     = RELEASE_WAIT;
          cnt_d       = CNT_W'(1);
          from_hold_d = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (!btn_s) begin
          state_d = from_hold_q ? HOLD : PRESSED;
          cnt_d   = '0;
        end else if (cnt_inc == DEB_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
          strt_d  = 1'b1;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign btn_if.STRTSTOP    = strt_q;
  assign btn_if.PRESS_PULSE = pulse_q;
  assign btn_if.RUN         = run_q;
  assign btn_if.LONG_PRESS  = long_q;

endmodule

// File: tb/tb_strtstop_conditioner.sv
// Scoreboard bench for strtstop_conditioner: directed button sequences, expected pulse events queued and checked by a monitor.
module tb_strtstop_conditioner;
  import stopwatch_pkg::*;

  typedef struct {
    int kind;   // 0 = press pulse, 1 = long press
    int cyc;
    int run;
  } evt_t;

  logic CLK = 1'b0;
  logic RESET_N;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   exp_run = 0;
  evt_t q[$];

  strtstop_conditioner_if bus();

  strtstop_conditioner dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .btn_if  (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push(input int kind, input int at, input int run);
    evt_t e;
    e.kind = kind;
    e.cyc  = at;
    e.run  = run;
    q.push_back(e);
  endtask

  // Monitor: every pulse the DUT presents must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (RESET_N === 1'b1 && (bus.PRESS_PULSE === 1'b1 || bus.LONG_PRESS === 1'b1)) begin
      chk("evt_queued", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        evt_t e;
        e = q.pop_front();
        chk("evt_kind", int'(bus.LONG_PRESS), e.kind);
        chk("evt_cycle", cyc, e.cyc);
        chk("evt_run", int'(bus.RUN), e.run);
        chk("evt_strtstop", int'(bus.STRTSTOP), 0);
      end
    end
  end

  task automatic release_check();
    bus.BTN_RAW = 1'b1;
    wait_cyc(17);
    chk("release_hold_strtstop", int'(bus.STRTSTOP), 0);
    wait_cyc(1);
    chk("release_done_strtstop", int'(bus.STRTSTOP), 1);
  endtask

  task automatic press_short(input int hold);
    exp_run = 1 - exp_run;
    push(0, cyc + 18, exp_run);
    bus.BTN_RAW = 1'b0;
    wait_cyc(17);
    chk("pre_accept_strtstop", int'(bus.STRTSTOP), 1);
    wait_cyc(1);
    chk("accept_strtstop", int'(bus.STRTSTOP), 0);
    wait_cyc(hold - 18);
    release_check();
    chk("short_run_level", int'(bus.RUN), exp_run);
    wait_cyc(20);
  endtask

  task automatic press_long(input int hold);
    exp_run = 1 - exp_run;
    push(0, cyc + 18, exp_run);
    push(1, cyc + 274, 0);
    bus.BTN_RAW = 1'b0;
    wait_cyc(hold);
    exp_run = 0;
    release_check();
    chk("long_run_level", int'(bus.RUN), 0);
    wait_cyc(20);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    RESET_N     = 1'b0;
    bus.BTN_RAW = 1'b0;
    wait_cyc(5);
    chk("rst_strtstop", int'(bus.STRTSTOP), 1);
    chk("rst_run", int'(bus.RUN), 0);
    chk("rst_pulse", int'(bus.PRESS_PULSE), 0);
    chk("rst_long", int'(bus.LONG_PRESS), 0);

    // Button still held across reset release reads as a fresh press.
    exp_run = 1;
    push(0, cyc + 18, 1);
    RESET_N = 1'b1;
    wait_cyc(100);
    release_check();
    chk("held_reset_run", int'(bus.RUN), 1);
    wait_cyc(20);

    press_short(100);
    press_short(100);

    for (int i = 0; i < 12; i++) begin
      bus.BTN_RAW = (i % 2 == 1);
      wait_cyc(5);
    end
    bus.BTN_RAW = 1'b1;
    wait_cyc(30);
    chk("bounce_strtstop", int'(bus.STRTSTOP), 1);
    chk("bounce_run", int'(bus.RUN), exp_run);

    exp_run = 1 - exp_run;
    push(0, cyc + 18, exp_run);
    bus.BTN_RAW = 1'b0;
    wait_cyc(50);
    bus.BTN_RAW = 1'b1;
    wait_cyc(10);
    bus.BTN_RAW = 1'b0;
    wait_cyc(5);
    chk("rel_bounce_mid_strtstop", int'(bus.STRTSTOP), 0);
    release_check();
    chk("rel_bounce_run", int'(bus.RUN), exp_run);
    wait_cyc(20);

    press_short(60);
    chk("pre_long_run", int'(bus.RUN), 1);
    press_long(400);
    press_long(400);

    press_short(60);
    chk("pre_midreset_run", int'(bus.RUN), 1);
    bus.BTN_RAW = 1'b0;
    wait_cyc(12);
    RESET_N = 1'b0;
    wait_cyc(2);
    chk("midrst_strtstop", int'(bus.STRTSTOP), 1);
    chk("midrst_run", int'(bus.RUN), 0);
    chk("midrst_pulse", int'(bus.PRESS_PULSE), 0);
    chk("midrst_long", int'(bus.LONG_PRESS), 0);
    chk("midrst_state", int'(dut.state_q), int'(IDLE));
    wait_cyc(20);
    bus.BTN_RAW = 1'b1;
    wait_cyc(5);
    RESET_N = 1'b1;
    wait_cyc(40);
    chk("post_midrst_strtstop", int'(bus.STRTSTOP), 1);
    chk("post_midrst_run", int'(bus.RUN), 0);

    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/strtstop_conditioner.md
# strtstop_conditioner

Front-end conditioner for the stopwatch's start/stop push-button, sitting directly upstream of the stopwatch core. Synchronises the raw, bouncing, active-low button into the CLK domain and debounces it. Drives the clean level-sensitive STRTSTOP input the core consumes, plus a one-cycle press pulse, a run/stop toggle state and a long-press clear request.

## Interface

- SYNC_STAGES, 2, flip-flop stages in the input synchroniser (min 2).
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples needed to accept a press or release (min 2).
- LONG_CYCLES, 256, cycles a press must be held after acceptance to raise LONG_PRESS (must exceed DEBOUNCE_CYCLES).
- CNT_W, 9, counter width; must satisfy 2^CNT_W > LONG_CYCLES.

- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- BTN_RAW  in  1  raw button, asynchronous, active-low (0 = pressed), bouncing.
- STRTSTOP  out  1  debounced button level to the stopwatch core; 1 = released, 0 = pressed.
- PRESS_PULSE  out  1  one-cycle high on each accepted press.
- RUN  out  1  run state; toggles on each accepted short press.
- LONG_PRESS  out  1  one-cycle high when a press has been held LONG_CYCLES cycles after acceptance.

## Operation

- Reset values: STRTSTOP=1, PRESS_PULSE=0, RUN=0, LONG_PRESS=0, FSM=IDLE, counter=0, synchroniser flops=1.
- BTN_RAW passes through the SYNC_STAGES chain. The FSM observes only the last stage, btn_s.
- FSM states:
  - IDLE: btn_s=1 → stay, cnt=0. btn_s=0 → PRESS_WAIT, cnt=1.
  - PRESS_WAIT: btn_s=0 → cnt++. On the cycle cnt reaches DEBOUNCE_CYCLES → PRESSED, cnt=0, STRTSTOP←0, PRESS_PULSE←1, RUN←~RUN. btn_s=1 at any point → IDLE, cnt=0 (bounce rejected, no outputs change).
  - PRESSED: btn_s=0 → cnt++. On the cycle cnt reaches LONG_CYCLES → HOLD, LONG_PRESS←1, RUN←0. btn_s=1 → RELEASE_WAIT, cnt=1.
  - HOLD: btn_s=0 → stay, cnt frozen. btn_s=1 → RELEASE_WAIT, cnt=1.
  - RELEASE_WAIT: btn_s=1 → cnt++. On the cycle cnt reaches DEBOUNCE_CYCLES → IDLE, STRTSTOP←1, cnt=0. btn_s=0 → return to the state held before RELEASE_WAIT (PRESSED or HOLD), cnt=0. STRTSTOP stays 0 throughout.
- A 1-bit flag records whether RELEASE_WAIT was entered from PRESSED or HOLD.
- LONG_PRESS overrides the toggle already applied at acceptance: RUN ends at 0 regardless of its prior value.
- Counters saturate and never wrap. cnt is compared with ==, and CNT_W is sized so no overflow is possible.
- All outputs are registered. No combinational path from BTN_RAW to any output.

## Timing

- Press latency: BTN_RAW falling edge (clean) to STRTSTOP=0 and PRESS_PULSE=1 is SYNC_STAGES + DEBOUNCE_CYCLES cycles (default 18). RUN updates in the same cycle.
- Release latency: the same, SYNC_STAGES + DEBOUNCE_CYCLES cycles to STRTSTOP=1.
- LONG_PRESS asserts LONG_CYCLES cycles after PRESS_PULSE, for exactly one cycle.
- Minimum accepted press-to-press spacing: 2·DEBOUNCE_CYCLES cycles of stable input.
- RESET_N assertion mid-press immediately forces all outputs to their reset values. After deassertion, a button still held reads as a new press once debounced (RUN→1).
- RESET_N deassertion is synchronised externally. The block does not resynchronise reset release.

## Structure

- Shared package stopwatch_pkg: FSM state enum (IDLE, PRESS_WAIT, PRESSED, HOLD, RELEASE_WAIT), default DEBOUNCE_CYCLES/LONG_CYCLES constants.
- One sub-module: sync_chain (parameterised SYNC_STAGES, reset value 1), reusable for other asynchronous inputs.
- FSM, counter and output registers live in the top module.

## Test plan

- Reset: RESET_N=0 with BTN_RAW=0 → STRTSTOP=1, RUN=0, PRESS_PULSE=0, LONG_PRESS=0. Release reset with button held → PRESS_PULSE at cycle 18, RUN=1.
- Clean short press: BTN_RAW=0 for 100 cycles, then 1 → PRESS_PULSE at cycle 18, STRTSTOP=0 from cycle 18 to cycle 118, RUN 0→1. A second identical press → RUN 1→0.
- Bounce rejection: BTN_RAW toggles every 5 cycles for 60 cycles, then settles at 1 → no PRESS_PULSE, STRTSTOP stays 1, RUN unchanged.
- Release bounce: after an accepted press, BTN_RAW goes high for 10 cycles, low for 5, then high → STRTSTOP stays 0 until 16 stable high samples, exactly one PRESS_PULSE.
- Long press: with RUN=1, hold BTN_RAW=0 for 400 cycles → PRESS_PULSE at cycle 18 (RUN=0), LONG_PRESS one cycle at cycle 274, RUN=0, no further pulses until release.
- Mid-operation reset: assert RESET_N at cycle 10 of PRESS_WAIT → no PRESS_PULSE, FSM=IDLE, all outputs at reset values.
